fetch_pair_unit: RTL and testbench

- Dual-issue instruction fetch front end that drives the two read addresses of the instruction ROM and collects the instruction pair the ROM returns one clock later.
- Keeps the fetch PC and tracks requests in flight with a credit counter; buffers returned pairs in a small FIFO.
- Presents each pair, with its PC, to decode over a valid/ready handshake.
- Sits between the ROM and the decode stage; accepts PC redirects from the branch/jump resolution logic.

---
 rtl/fetch_pair_unit.sv | 195 +++++++++++++++++++
 tb/tb_fetch_pair_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_unit.sv
// fetch_pair_unit: dual-issue fetch front end. It drives two ROM word
// addresses from the fetch PC and collects the returned instruction pair
// one cycle later. Each returned pair is buffered in a DEPTH-entry FIFO
// and presented to decode over a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   rom_addr1/2             ROM word addresses pc[11:2] and pc[11:2]+1
//   rom_instr1/2            ROM data, one cycle after the address
//   redirect_valid/pc       load a new fetch PC and flush
//   out_valid/out_ready     pair handshake toward decode
//   out_pc, out_instr1/2    FIFO head (slot 2 PC is out_pc+4)
//   out_slot2_valid         slot 2 of the head is to be executed
// Optional: define FETCH_JAL_PREDECODE_EN to follow JALs found in
// returned pairs without waiting for the back end.
module fetch_pair_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  rom_addr1,
    output logic [9:0]  rom_addr2,
    input  logic [31:0] rom_instr1,
    input  logic [31:0] rom_instr2,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr1,
    output logic [31:0] out_instr2,
    output logic        out_slot2_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic        slot2_valid;
    } entry_t;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [OW:0]   credit;
    logic          pd_hit;
    logic          pd_slot2_valid;
    logic [31:0]   pd_target;
    entry_t        head;
    entry_t        push_entry;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // The ROM samples these every cycle; unrequested data is ignored.
    assign rom_addr1 = pc_q[11:2];
    assign rom_addr2 = pc_q[11:2] + 10'd1;

    assign head            = fifo_q[rd_ptr_q];
    assign out_valid       = (occ_q != '0);
    assign out_pc          = head.pc;
    assign out_instr1      = head.instr1;
    assign out_instr2      = head.instr2;
    assign out_slot2_valid = out_valid & head.slot2_valid;

    assign pop  = out_valid & out_ready;
    assign push = inflight_q & ~redirect_valid;

    // Entries already owned (buffered or in flight) after this cycle's pop.
    // pop implies occ >= 1, so this never underflows.
    assign credit = {1'b0, occ_q}
                  + {{OW{1'b0}}, inflight_q}
                  - {{OW{1'b0}}, pop};

    assign issue = ~redirect_valid & ~pd_hit
                 & (credit < (OW + 1)'(DEPTH));

`ifdef FETCH_JAL_PREDECODE_EN
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    function automatic logic [31:0] jal_offset(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    logic s1_jal;
    logic s2_jal;

    // Slot 1 takes priority; a taken slot-1 JAL kills slot 2.
    always_comb begin
        s1_jal         = (rom_instr1[6:0] == OPC_JAL);
        s2_jal         = (rom_instr2[6:0] == OPC_JAL);
        pd_hit         = push & (s1_jal | s2_jal);
        pd_slot2_valid = ~s1_jal;
        if (s1_jal) begin
            pd_target = inflight_pc_q + jal_offset(rom_instr1);
        end else begin
            pd_target = inflight_pc_q + 32'd4 + jal_offset(rom_instr2);
        end
    end
`else
    assign pd_hit         = 1'b0;
    assign pd_slot2_valid = 1'b1;
    assign pd_target      = '0;
`endif

    assign push_entry = {inflight_pc_q, rom_instr1, rom_instr2, pd_slot2_valid};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        fifo_d        = fifo_q;

        if (issue) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd8;
        end

        if (pd_hit) begin
            pc_d = pd_target;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (push & ~pop) begin
            occ_d = occ_q + OW'(1);
        end else if (~push & pop) begin
            occ_d = occ_q - OW'(1);
        end

        // Redirect wins over everything; a pop this cycle still reaches decode.
        if (redirect_valid) begin
            pc_d     = redirect_pc & ~32'h3;
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= PC_RST;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            fifo_q        <= fifo_d;
        end
    end

    // Credit accounting keeps buffered + in-flight <= DEPTH.
    push_not_full: assert property (
        @(posedge clk) disable iff (!rst_n)
        push |-> (occ_q < OW'(DEPTH))
    );

endmodule

// File: tb/tb_fetch_pair_unit.sv
// tb_fetch_pair_unit: scoreboard bench for fetch_pair_unit with a
// registered ROM model and a pair-stream reference model.
module tb_fetch_pair_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        s2v;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rom_addr1;
    logic [9:0]  rom_addr2;
    logic [31:0] rom_instr1;
    logic [31:0] rom_instr2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr1;
    logic [31:0] out_instr2;
    logic        out_slot2_valid;

    logic [31:0] rom [1024];
    pair_t       exp_q [$];
    pair_t       mon_p;
    logic [31:0] gen_pc;
    int          passed = 0;
    int          total = 0;
    int          pop_count = 0;
    int          pop_start;
    bit          found;

    fetch_pair_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr1      (rom_addr1),
        .rom_addr2      (rom_addr2),
        .rom_instr1     (rom_instr1),
        .rom_instr2     (rom_instr2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr1     (out_instr1),
        .out_instr2     (out_instr2),
        .out_slot2_valid(out_slot2_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_instr1 <= rom[rom_addr1];
        rom_instr2 <= rom[rom_addr2];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

`ifdef FETCH_JAL_PREDECODE_EN
    function automatic logic [31:0] jal_off(input logic [31:0] ins);
        logic [20:0] imm;
        imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return {{11{imm[20]}}, imm};
    endfunction
`endif

    // Next pair of the architectural fetch stream starting at gen_pc.
    task automatic push_next();
        pair_t       p;
        logic [9:0]  a1;
        logic [9:0]  a2;
        logic [31:0] nxt;
        a1    = gen_pc[11:2];
        a2    = a1 + 10'd1;
        p.pc  = gen_pc;
        p.i1  = rom[a1];
        p.i2  = rom[a2];
        p.s2v = 1'b1;
        nxt   = gen_pc + 32'd8;
`ifdef FETCH_JAL_PREDECODE_EN
        if (p.i1[6:0] == 7'h6F) begin
            p.s2v = 1'b0;
            nxt   = gen_pc + jal_off(p.i1);
        end else if (p.i2[6:0] == 7'h6F) begin
            nxt = gen_pc + 32'd4 + jal_off(p.i2);
        end
`endif
        exp_q.push_back(p);
        gen_pc = nxt;
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            push_next();
        end
    endtask

    task automatic flush_to(input logic [31:0] tgt);
        exp_q.delete();
        gen_pc = tgt & ~32'h3;
        refill();
    endtask

    always @(posedge clk) begin
        refill();
    end

    // Monitor: every accepted pair must be the next one of the stream.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!out_valid) begin
                check("s2v_idle", 32'(out_slot2_valid), 32'd0);
            end
            if (out_valid && out_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL sb_empty: got pc %h, expected no pair", out_pc);
                end else begin
                    mon_p = exp_q.pop_front();
                    check("sb_pc", out_pc, mon_p.pc);
                    check("sb_instr1", out_instr1, mon_p.i1);
                    check("sb_instr2", out_instr2, mon_p.i2);
                    check("sb_s2v", 32'(out_slot2_valid), 32'(mon_p.s2v));
                end
            end
        end
    end

    task automatic do_reset(input bit rdy);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = rdy;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush_to(32'h0);
    endtask

    task automatic check_startup();
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr1", out_instr1, 32'd0);
        check("rst_instr2", out_instr2, 32'd0);
        check("rst_s2v", 32'(out_slot2_valid), 32'd0);
        check("rst_addr1", 32'(rom_addr1), 32'd0);
        check("rst_addr2", 32'(rom_addr2), 32'd1);
        @(negedge clk);
        check("c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("c2_valid", 32'(out_valid), 32'd1);
        check("c2_pc", out_pc, 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        #1;
        flush_to(tgt);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic redirect_check(input logic [31:0] tgt,
                                  input logic [31:0] a1,
                                  input logic [31:0] a2,
                                  input logic [31:0] w1,
                                  input logic [31:0] w2);
        do_redirect(tgt);
        @(negedge clk);
        check("rd_n1_valid", 32'(out_valid), 32'd0);
        check("rd_n1_addr1", 32'(rom_addr1), a1);
        check("rd_n1_addr2", 32'(rom_addr2), a2);
        @(negedge clk);
        check("rd_n2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rd_n3_valid", 32'(out_valid), 32'd1);
        check("rd_n3_pc", out_pc, tgt);
        check("rd_n3_instr1", out_instr1, w1);
        check("rd_n3_instr2", out_instr2, w2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        rom_instr1     = '0;
        rom_instr2     = '0;
        gen_pc         = '0;
        for (int k = 0; k < 1024; k++) begin
            rom[k] = 32'(k);
        end
        repeat (2) @(posedge clk);

        // Startup latency and back-to-back stream.
        do_reset(1'b1);
        check_startup();
        repeat (5) begin
            @(negedge clk);
            check("stream_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure from reset: head holds, issue stops at pc 16.
        do_reset(1'b0);
        repeat (6) @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_pc", out_pc, 32'd0);
        check("bp_instr1", out_instr1, 32'd0);
        check("bp_instr2", out_instr2, 32'd1);
        check("bp_addr1", 32'(rom_addr1), 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("bp_nobubble", 32'(out_valid), 32'd1);
        end

        // Redirect mid-stream.
        redirect_check(32'h100, 32'h40, 32'h41, 32'd64, 32'd65);
        repeat (3) @(negedge clk);

        // Address wrap.
        redirect_check(32'hFFC, 32'd1023, 32'd0, 32'd1023, 32'd0);
        @(negedge clk);
        check("wrap_pc", out_pc, 32'h1004);
        check("wrap_instr1", out_instr1, 32'd1);
        check("wrap_instr2", out_instr2, 32'd2);

        // Reset while the FIFO is full.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("full_valid", 32'(out_valid), 32'd1);
        do_reset(1'b1);
        check_startup();
        repeat (4) @(negedge clk);

`ifdef FETCH_JAL_PREDECODE_EN
        rom[2] = 32'h0400006F;
        do_reset(1'b1);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_pc == 32'd8) found = 1'b1;
        end
        check("jal_seen", 32'(found), 32'd1);
        if (found) begin
            check("jal_instr1", out_instr1, 32'h0400006F);
            check("jal_s2v", 32'(out_slot2_valid), 32'd0);
        end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_pc != 32'd8) found = 1'b1;
        end
        check("jal_next_seen", 32'(found), 32'd1);
        check("jal_next_pc", out_pc, 32'h48);
        rom[2] = 32'd2;
`endif

        // Random traffic: random ROM, ready and redirects.
        for (int k = 0; k < 1024; k++) begin
            rom[k] = $urandom;
        end
        do_reset(1'b1);
        pop_start = pop_count;
        repeat (1500) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                @(negedge clk);
                #1;
                flush_to(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (10) @(negedge clk);
        check("rand_progress", 32'((pop_count - pop_start) > 300), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
